// File: rtl/hamming_tx_scheduler.sv
// Round-robin scheduler that shares one 8->12 Hamming encoder among NREQ byte requesters.
// Define HMS_TIMEOUT_EN to add the WAIT-state abort counter and the sticky err_timeout output.
module hamming_tx_scheduler #(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sched_en,
  input  logic [NREQ-1:0]     req,
  input  logic [8*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]     req_ack,
  output logic                enc_en,
  output logic                enc_fram,
  output logic [7:0]          enc_data,
  input  logic                enc_qvld,
  input  logic [11:0]         enc_dout,
  output logic                cw_valid,
  input  logic                cw_ready,
  output logic [11:0]         cw_data,
  output logic [IDW-1:0]      cw_src,
  output logic                busy
`ifdef HMS_TIMEOUT_EN
  ,
  output logic                err_timeout
`endif
);

  if ((NREQ < 2) || (NREQ > 8) || ((2 ** IDW) < NREQ) || (TIMEOUT < 1)) begin : g_bad_cfg
    $error("hamming_tx_scheduler: invalid NREQ/IDW/TIMEOUT combination");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FRAM = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic              enc_en_q, enc_en_d;
  logic              fram_q, fram_d;
  logic [7:0]        enc_data_q, enc_data_d;
  logic              cw_valid_q, cw_valid_d;
  logic [11:0]       cw_data_q, cw_data_d;
  logic [IDW-1:0]    cw_src_q, cw_src_d;
  logic              busy_q, busy_d;

  logic              gnt_found_s;
  logic [IDW-1:0]    gnt_idx_s;
  logic [IDW:0]      scan_sum_s;
  logic [IDW:0]      scan_idx_s;
  logic              scan_hit_s;

`ifdef HMS_TIMEOUT_EN
  localparam int TW = ($clog2(TIMEOUT + 1) < 4) ? 4 : $clog2(TIMEOUT + 1);
  logic [TW-1:0]     wait_cnt_q, wait_cnt_d;
  logic              err_q, err_d;
`endif

  // Round-robin search: first set request at or above rr_ptr, wrapping modulo NREQ.
  always_comb begin
    gnt_found_s = 1'b0;
    gnt_idx_s   = '0;
    scan_sum_s  = '0;
    scan_idx_s  = '0;
    scan_hit_s  = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      scan_sum_s  = {1'b0, rr_ptr_q} + (IDW+1)'(k);
      scan_idx_s  = (scan_sum_s >= (IDW+1)'(NREQ)) ? (scan_sum_s - (IDW+1)'(NREQ)) : scan_sum_s;
      scan_hit_s  = req[scan_idx_s[IDW-1:0]] & ~gnt_found_s;
      gnt_idx_s   = scan_hit_s ? scan_idx_s[IDW-1:0] : gnt_idx_s;
      gnt_found_s = gnt_found_s | scan_hit_s;
    end
  end

  // Next-state and next-output logic; every output is the registered image of its _d value.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    ack_d      = '0;
    fram_d     = 1'b0;
    enc_data_d = enc_data_q;
    cw_valid_d = cw_valid_q;
    cw_data_d  = cw_data_q;
    cw_src_d   = cw_src_q;
`ifdef HMS_TIMEOUT_EN
    wait_cnt_d = wait_cnt_q;
    err_d      = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (sched_en && gnt_found_s) begin
          ack_d[gnt_idx_s] = 1'b1;
          enc_data_d       = req_data[{gnt_idx_s, 3'b000} +: 8];
          cw_src_d         = gnt_idx_s;
          rr_ptr_d         = (gnt_idx_s == IDW'(NREQ - 1)) ? '0 : (gnt_idx_s + IDW'(1));
          state_d          = S_FRAM;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FRAM: begin
        fram_d  = 1'b1;
        state_d = S_WAIT;
`ifdef HMS_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
      end
      S_WAIT: begin
        if (enc_qvld) begin
          cw_data_d  = enc_dout;
          cw_valid_d = 1'b1;
          state_d    = S_HOLD;
        end else begin
`ifdef HMS_TIMEOUT_EN
          // Abort leaves rr_ptr as already advanced at grant time.
          if (wait_cnt_q == TW'(TIMEOUT - 1)) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            wait_cnt_d = wait_cnt_q + TW'(1);
            state_d    = S_WAIT;
          end
`else
          state_d = S_WAIT;
`endif
        end
      end
      S_HOLD: begin
        if (cw_valid_q && cw_ready) begin
          cw_valid_d = 1'b0;
          state_d    = S_IDLE;
        end else begin
          state_d = S_HOLD;
        end
      end
      default: begin
        state_d    = S_IDLE;
        cw_valid_d = 1'b0;
      end
    endcase
    busy_d   = (state_d != S_IDLE);
    // Keeping the encoder enabled while busy stops its pipeline freezing mid-frame.
    enc_en_d = sched_en | busy_d;
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= '0;
      ack_q      <= '0;
      enc_en_q   <= 1'b0;
      fram_q     <= 1'b0;
      enc_data_q <= 8'h00;
      cw_valid_q <= 1'b0;
      cw_data_q  <= 12'h000;
      cw_src_q   <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      ack_q      <= ack_d;
      enc_en_q   <= enc_en_d;
      fram_q     <= fram_d;
      enc_data_q <= enc_data_d;
      cw_valid_q <= cw_valid_d;
      cw_data_q  <= cw_data_d;
      cw_src_q   <= cw_src_d;
      busy_q     <= busy_d;
    end
  end

`ifdef HMS_TIMEOUT_EN
  // WAIT-state watchdog counter and sticky timeout flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
    end
  end

  assign err_timeout = err_q;
`endif

  assign req_ack  = ack_q;
  assign enc_en   = enc_en_q;
  assign enc_fram = fram_q;
  assign enc_data = enc_data_q;
  assign cw_valid = cw_valid_q;
  assign cw_data  = cw_data_q;
  assign cw_src   = cw_src_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_hamming_tx_scheduler.sv
// Directed self-checking bench for hamming_tx_scheduler with a 5-clock encoder stand-in.
// Timeout scenario is compiled only when HMS_TIMEOUT_EN is defined.
module tb_hamming_tx_scheduler;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              sched_en = 1'b0;
  logic [NREQ-1:0]   req = '0;
  logic [8*NREQ-1:0] req_data = '0;
  logic [NREQ-1:0]   req_ack;
  logic              enc_en, enc_fram;
  logic [7:0]        enc_data;
  logic              enc_qvld;
  logic [11:0]       enc_dout;
  logic              cw_valid;
  logic              cw_ready = 1'b0;
  logic [11:0]       cw_data;
  logic [IDW-1:0]    cw_src;
  logic              busy;
  logic              err_timeout;
  logic              enc_stall = 1'b0;
  logic [29:0]       outs;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hamming_tx_scheduler #(.NREQ(NREQ), .IDW(IDW), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .sched_en(sched_en), .req(req), .req_data(req_data),
    .req_ack(req_ack), .enc_en(enc_en), .enc_fram(enc_fram), .enc_data(enc_data),
    .enc_qvld(enc_qvld), .enc_dout(enc_dout), .cw_valid(cw_valid), .cw_ready(cw_ready),
    .cw_data(cw_data), .cw_src(cw_src), .busy(busy)
`ifdef HMS_TIMEOUT_EN
    , .err_timeout(err_timeout)
`endif
  );

`ifndef HMS_TIMEOUT_EN
  assign err_timeout = 1'b0;
`endif

  assign outs = {req_ack, enc_en, enc_fram, enc_data, cw_valid, cw_data, cw_src, busy};

  // Encoder stand-in: frame strobe sampled at one edge yields qvld four edges later.
  function automatic logic [11:0] enc_ref(input logic [7:0] d);
    case (d)
      8'hFF:   return 12'hFF4;
      8'h01:   return 12'h005;
      8'h00:   return 12'h000;
      default: return {d, 4'h9};
    endcase
  endfunction

  logic [4:0]  pv;
  logic [11:0] pd [0:4];
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      pv <= '0;
      for (int i = 0; i < 5; i++) pd[i] <= '0;
    end else begin
      pv    <= {pv[3:0], enc_fram & enc_en & ~enc_stall};
      pd[0] <= enc_ref(enc_data);
      for (int i = 1; i < 5; i++) pd[i] <= pd[i-1];
    end
  end
  assign enc_qvld = pv[4];
  assign enc_dout = pd[4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; sched_en = 1'b0; req = '0; cw_ready = 1'b0; enc_stall = 1'b0;
    tick(); tick();
    rst = 1'b1;
  endtask

  task automatic wait_ack(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (req_ack != '0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_cw(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (cw_valid === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; sched_en = 1'b1; req = 4'b1111;
    tick(); tick();
    n_checks++; if (outs !== 30'd0) begin n_fail++; $display("FAIL reset_outs: got %h expected %h", outs, 30'd0); end
    n_checks++; if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err_timeout); end
    sched_en = 1'b0; req = '0;
    rst = 1'b1;
    tick();
    n_checks++; if (outs !== 30'd0) begin n_fail++; $display("FAIL idle_outs: got %h expected %h", outs, 30'd0); end
  endtask

  task automatic test_single();
    do_reset();
    req_data = 32'h0000_00FF; cw_ready = 1'b1; sched_en = 1'b1; req = 4'b0001;
    tick();
    n_checks++; if (req_ack !== 4'b0001) begin n_fail++; $display("FAIL single_ack: got %b expected 0001", req_ack); end
    n_checks++; if (enc_fram !== 1'b0 || enc_data !== 8'hFF || busy !== 1'b1) begin n_fail++; $display("FAIL single_grant: fram %b data %h busy %b expected 0 ff 1", enc_fram, enc_data, busy); end
    req = '0;
    tick();
    n_checks++; if (req_ack !== 4'b0000 || enc_fram !== 1'b1) begin n_fail++; $display("FAIL single_fram: ack %b fram %b expected 0000 1", req_ack, enc_fram); end
    tick();
    n_checks++; if (enc_fram !== 1'b0 || enc_data !== 8'hFF) begin n_fail++; $display("FAIL single_fram_end: fram %b data %h expected 0 ff", enc_fram, enc_data); end
    repeat (4) tick();
    n_checks++; if (enc_qvld !== 1'b1 || cw_valid !== 1'b0) begin n_fail++; $display("FAIL single_qvld: qvld %b cw_valid %b expected 1 0", enc_qvld, cw_valid); end
    tick();
    n_checks++; if (cw_valid !== 1'b1 || cw_data !== 12'hFF4 || cw_src !== 2'd0) begin n_fail++; $display("FAIL single_cw: valid %b data %h src %0d expected 1 ff4 0", cw_valid, cw_data, cw_src); end
    tick();
    n_checks++; if (cw_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL single_done: valid %b busy %b expected 0 0", cw_valid, busy); end
  endtask

  task automatic test_round_robin();
    logic [3:0]  exp_ack [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [11:0] exp_cw  [5] = '{12'h005, 12'h000, 12'hFF4, 12'h005, 12'h005};
    logic [1:0]  exp_src [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    bit ok;
    do_reset();
    req_data = {8'h01, 8'hFF, 8'h00, 8'h01}; cw_ready = 1'b1; sched_en = 1'b1; req = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      wait_ack(ok);
      n_checks++; if (req_ack !== exp_ack[t]) begin n_fail++; $display("FAIL rr_ack[%0d]: got %b expected %b", t, req_ack, exp_ack[t]); end
      wait_cw(ok);
      n_checks++; if (cw_data !== exp_cw[t] || cw_src !== exp_src[t]) begin n_fail++; $display("FAIL rr_cw[%0d]: data %h src %0d expected %h %0d", t, cw_data, cw_src, exp_cw[t], exp_src[t]); end
    end
    req = '0;
    tick();
  endtask

  task automatic test_backpressure();
    bit ok;
    int bad;
    do_reset();
    req_data = 32'h0000_FF00; cw_ready = 1'b0; sched_en = 1'b1; req = 4'b0010;
    wait_ack(ok);
    n_checks++; if (req_ack !== 4'b0010) begin n_fail++; $display("FAIL bp_ack: got %b expected 0010", req_ack); end
    wait_cw(ok);
    n_checks++; if (cw_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid: got %b expected 1", cw_valid); end
    bad = 0;
    repeat (20) begin
      tick();
      if (cw_valid !== 1'b1 || cw_data !== 12'hFF4 || cw_src !== 2'd1 || req_ack !== 4'b0000) bad++;
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL bp_hold: %0d unstable cycles expected 0", bad); end
    cw_ready = 1'b1;
    tick();
    n_checks++; if (cw_valid !== 1'b0 || req_ack !== 4'b0000) begin n_fail++; $display("FAIL bp_release: valid %b ack %b expected 0 0000", cw_valid, req_ack); end
    tick();
    n_checks++; if (req_ack !== 4'b0010) begin n_fail++; $display("FAIL bp_next_ack: got %b expected 0010", req_ack); end
    req = '0;
    wait_cw(ok);
    n_checks++; if (cw_data !== 12'hFF4) begin n_fail++; $display("FAIL bp_second_cw: got %h expected ff4", cw_data); end
    tick();
  endtask

  task automatic test_sched_gating();
    bit ok;
    int bad;
    do_reset();
    req_data = 32'h0001_0000; cw_ready = 1'b1; sched_en = 1'b0; req = 4'b0100;
    bad = 0;
    repeat (5) begin
      tick();
      if (req_ack !== 4'b0000 || busy !== 1'b0 || enc_en !== 1'b0) bad++;
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL gate_block: %0d bad cycles expected 0", bad); end
    sched_en = 1'b1;
    tick();
    n_checks++; if (req_ack !== 4'b0100 || enc_en !== 1'b1) begin n_fail++; $display("FAIL gate_ack: ack %b en %b expected 0100 1", req_ack, enc_en); end
    req = '0;
    tick(); tick();
    sched_en = 1'b0;
    wait_cw(ok);
    n_checks++; if (cw_valid !== 1'b1 || cw_data !== 12'h005 || cw_src !== 2'd2) begin n_fail++; $display("FAIL gate_cw: valid %b data %h src %0d expected 1 005 2", cw_valid, cw_data, cw_src); end
    n_checks++; if (enc_en !== 1'b1) begin n_fail++; $display("FAIL gate_en_busy: got %b expected 1", enc_en); end
    tick();
    n_checks++; if (busy !== 1'b0 || enc_en !== 1'b0) begin n_fail++; $display("FAIL gate_idle: busy %b en %b expected 0 0", busy, enc_en); end
  endtask

  task automatic test_reset_mid_wait();
    bit ok;
    do_reset();
    req_data = 32'h00FF_0001; cw_ready = 1'b1; sched_en = 1'b1; req = 4'b0010;
    wait_ack(ok);
    n_checks++; if (req_ack !== 4'b0010) begin n_fail++; $display("FAIL rst_first_ack: got %b expected 0010", req_ack); end
    req = '0;
    tick(); tick(); tick();
    req = 4'b0101;
    rst = 1'b0;
    #1;
    n_checks++; if (outs !== 30'd0) begin n_fail++; $display("FAIL rst_async: got %h expected %h", outs, 30'd0); end
    tick(); tick();
    n_checks++; if (outs !== 30'd0) begin n_fail++; $display("FAIL rst_held: got %h expected %h", outs, 30'd0); end
    rst = 1'b1;
    tick();
    n_checks++; if (req_ack !== 4'b0001) begin n_fail++; $display("FAIL rst_rearb: got %b expected 0001", req_ack); end
    req = '0;
    wait_cw(ok);
    n_checks++; if (cw_data !== 12'h005 || cw_src !== 2'd0) begin n_fail++; $display("FAIL rst_cw: data %h src %0d expected 005 0", cw_data, cw_src); end
    tick();
  endtask

`ifdef HMS_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    int bad;
    do_reset();
    req_data = 32'h0000_0001; cw_ready = 1'b1; sched_en = 1'b1; enc_stall = 1'b1; req = 4'b0001;
    wait_ack(ok);
    n_checks++; if (req_ack !== 4'b0001) begin n_fail++; $display("FAIL to_ack: got %b expected 0001", req_ack); end
    req = '0;
    tick();
    repeat (14) tick();
    n_checks++; if (busy !== 1'b1 || err_timeout !== 1'b0) begin n_fail++; $display("FAIL to_before: busy %b err %b expected 1 0", busy, err_timeout); end
    tick();
    n_checks++; if (busy !== 1'b0 || err_timeout !== 1'b1 || cw_valid !== 1'b0) begin n_fail++; $display("FAIL to_abort: busy %b err %b valid %b expected 0 1 0", busy, err_timeout, cw_valid); end
    bad = 0;
    repeat (10) begin
      tick();
      if (err_timeout !== 1'b1 || cw_valid !== 1'b0) bad++;
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL to_sticky: %0d bad cycles expected 0", bad); end
    enc_stall = 1'b0; req = 4'b0011;
    wait_ack(ok);
    n_checks++; if (req_ack !== 4'b0010) begin n_fail++; $display("FAIL to_rr: got %b expected 0010", req_ack); end
    req = '0;
    wait_cw(ok);
    n_checks++; if (cw_valid !== 1'b1 || cw_src !== 2'd1 || err_timeout !== 1'b1) begin n_fail++; $display("FAIL to_recover: valid %b src %0d err %b expected 1 1 1", cw_valid, cw_src, err_timeout); end
    tick();
  endtask
`endif

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_sched_gating();
    test_reset_mid_wait();
`ifdef HMS_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hamming_tx_scheduler.md
Name: hamming_tx_scheduler

Overview:
- Shares the single 8→12 Hamming encoder among NREQ byte requesters inside the SPI single-bit DC slave.
- Arbitrates requests round-robin and sequences the encoder's enable, frame-strobe and data inputs.
- Waits for the encoder's frame-valid, then captures the 12-bit codeword.
- Holds the codeword in an output register under a valid/ready handshake for the SPI shifter.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of source ID; must satisfy 2^IDW ≥ NREQ.
- TIMEOUT, 15, maximum clocks spent in WAIT before abort; only used with HMS_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- sched_en  in  1  permits new grants.
- req  in  NREQ  per-requester request level; held until acked.
- req_data  in  8*NREQ  request byte; requester i uses bits [8i+7:8i].
- req_ack  out  NREQ  one-clock grant/accept pulse.
- enc_en  out  1  encoder enable.
- enc_fram  out  1  encoder frame strobe.
- enc_data  out  8  encoder byte input.
- enc_qvld  in  1  encoder frame-valid.
- enc_dout  in  12  encoder codeword.
- cw_valid  out  1  codeword available.
- cw_ready  in  1  shifter accepts codeword.
- cw_data  out  12  captured codeword.
- cw_src  out  IDW  index of the requester that owns cw_data.
- busy  out  1  high in any state other than IDLE.
- err_timeout  out  1  sticky timeout flag; present only with HMS_TIMEOUT_EN.

Behaviour:
- Reset (rst=0): state IDLE, rr_ptr=0. Every output is 0, including req_ack, enc_en, enc_fram, enc_data, cw_valid, cw_data, cw_src, busy and err_timeout.
- All outputs are registered.
- enc_en is registered as (sched_en | busy); the encoder pipeline therefore never freezes mid-frame.
- IDLE:
  - If sched_en=1 and any req bit is set, the grant goes to the first set bit searching from rr_ptr upward, wrapping modulo NREQ.
  - At that edge: req_ack[g]=1 for one clock; enc_data <= req_data[g]; cw_src <= g; rr_ptr <= (g+1) mod NREQ; go to FRAM.
- FRAM: enc_fram=1 for exactly one clock, with enc_data stable. Go to WAIT.
- WAIT:
  - enc_fram=0.
  - On the first clock enc_qvld is sampled high: cw_data <= enc_dout; cw_valid <= 1; go to HOLD.
- HOLD:
  - cw_valid, cw_data and cw_src are held constant while cw_ready=0.
  - On an edge with cw_valid=1 and cw_ready=1: cw_valid <= 0; go to IDLE.
  - No new grant is issued in the same cycle; the minimum gap between acks is 1 IDLE clock.
- Simultaneous requests: exactly one req_ack bit pulses per transaction.
  - After reset, requester 0 wins over all others.
  - After a grant to g, requester g has lowest priority in the next arbitration.
- req deasserted before grant: no ack and no effect. req held after ack: treated as a new request in the next IDLE.
- sched_en=0 mid-transaction: the transaction completes; only new grants are blocked.
- An enc_qvld already high on entry to WAIT (stale) is not filtered. The encoder guarantees qvld low on entry because each frame strobe lasts one clock.
- Reset asserted mid-operation: immediate return to reset values. Any in-flight codeword is discarded.
- Transaction latency with the current 5-clock encoder: ack edge → cw_valid edge = 7 clocks.

Optional Feature:
- Macro HMS_TIMEOUT_EN.
- When defined:
  - A 4-bit or wider counter runs in WAIT.
  - If enc_qvld is not seen within TIMEOUT clocks, set err_timeout=1 (sticky, cleared only by reset) and return to IDLE with cw_valid=0.
  - rr_ptr keeps its already-advanced value.
- When undefined: there is no counter and no err_timeout port, and WAIT waits indefinitely.

Test Plan:
- Reset then single request: req=0001, req_data[7:0]=0xFF, cw_ready=1 → req_ack=0001 for 1 clock; enc_fram pulses 1 clock later; cw_valid rises the clock after enc_qvld; cw_data=0xFF4; cw_src=0.
- Round-robin with all requests held: req=1111, bytes 0x01/0x00/0xFF/0x01, cw_ready=1 → acks in order 0,1,2,3,0; cw_data sequence 0x005, 0x000, 0xFF4, 0x005; exactly one ack bit per transaction.
- Backpressure: cw_ready=0 for 20 clocks after cw_valid → cw_data/cw_src stable; no further req_ack. Raising cw_ready completes the transfer, and the next ack follows ≥1 IDLE clock later.
- sched_en gating: sched_en=0 with req=0100 → no ack, busy=0. Drop sched_en during WAIT → the transaction still delivers cw_valid.
- Reset mid-WAIT: assert rst=0 for 2 clocks → all outputs 0. After release, the still-pending request re-arbitrates from rr_ptr=0.
- (HMS_TIMEOUT_EN) Tie enc_qvld=0, TIMEOUT=15 → return to IDLE after 15 WAIT clocks; err_timeout=1 and stays set; cw_valid never asserts.
